ibis_tmds_timing: RTL and testbench

Video timing controller and scheduler for the three TMDS lanes (encoder + serial pump per lane).
- Divides the serial-rate clock into a pixel strobe (1 in 10 cycles) that paces encoder loads.
- Walks horizontal and vertical raster counters and drives per-lane data_enable, control and pixel data.
- Pulls pixels from an upstream source with a valid/ready handshake. Handles run/stop sequencing at frame boundaries and flags underflow.

---
 rtl/ibis_tmds_timing.sv | 148 ++++++++++++++
 tb/tb_ibis_tmds_timing.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibis_tmds_timing.sv
// ibis_tmds_timing: pixel-rate strobe, raster counters and pixel scheduling for three TMDS lanes.
// Optional macro IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflow counter port.
module ibis_tmds_timing #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter int unsigned SYNC_POL        = 0,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          in_run,
  input  logic          in_clear_status,
  input  logic          in_pixel_valid,
  input  logic [23:0]   in_pixel_data,
  output logic          out_pixel_ready,
  output logic          out_tmds_enable,
  output logic          out_pixel_strobe,
  output logic          out_data_enable,
  output logic [1:0]    out_control0,
  output logic [23:0]   out_data,
  output logic [HW-1:0] out_x,
  output logic [VW-1:0] out_y,
  output logic          out_frame_start,
  output logic          out_underflow
`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]   out_underflow_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PENDING} state_t;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ON = (SYNC_POL != 0);

  state_t        state;
  logic [3:0]    phase;
  logic [HW-1:0] nx_h;
  logic [VW-1:0] nx_v;

  logic running, strobe, at_origin, go_idle;
  logic load_active, load_hsync, load_vsync, underflow_evt;

  function automatic logic in_range(input int unsigned p, input int unsigned lo,
                                    input int unsigned hi);
    return (p >= lo) && (p < hi);
  endfunction

  always_comb begin
    running       = (state != IDLE);
    strobe        = running && (phase == 4'd9);
    at_origin     = (nx_h == '0) && (nx_v == '0);
    // Stopping is only allowed on the strobe that would start a new frame.
    go_idle       = strobe && (state == STOP_PENDING) && !in_run && at_origin;
    load_active   = in_range(32'(nx_h), 0, H_ACTIVE) && in_range(32'(nx_v), 0, V_ACTIVE);
    load_hsync    = in_range(32'(nx_h), H_ACTIVE + H_FRONT, H_ACTIVE + H_FRONT + H_SYNC);
    load_vsync    = in_range(32'(nx_v), V_ACTIVE + V_FRONT, V_ACTIVE + V_FRONT + V_SYNC);
    out_pixel_ready  = strobe && load_active && !go_idle;
    out_pixel_strobe = strobe;
    out_tmds_enable  = running;
    underflow_evt    = out_pixel_ready && !in_pixel_valid;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      phase           <= '0;
      nx_h            <= '0;
      nx_v            <= '0;
      out_x           <= '0;
      out_y           <= '0;
      out_data_enable <= 1'b0;
      out_frame_start <= 1'b0;
      out_control0    <= {2{~SYNC_ON}};
      out_data        <= '0;
      out_underflow   <= 1'b0;
    end else begin
      if (in_clear_status) out_underflow <= 1'b0;
      if (underflow_evt)   out_underflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (in_run) begin
            state <= RUN;
            phase <= '0;
            nx_h  <= '0;
            nx_v  <= '0;
          end
        end
        RUN, STOP_PENDING: begin
          phase <= (phase == 4'd9) ? '0 : phase + 4'd1;
          if (go_idle) begin
            state           <= IDLE;
            out_x           <= '0;
            out_y           <= '0;
            out_data_enable <= 1'b0;
            out_frame_start <= 1'b0;
            out_control0    <= {2{~SYNC_ON}};
            out_data        <= '0;
          end else begin
            state <= in_run ? RUN : STOP_PENDING;
            if (strobe) begin
              out_x           <= nx_h;
              out_y           <= nx_v;
              out_frame_start <= at_origin;
              out_data_enable <= load_active;
              out_control0    <= {load_vsync ? SYNC_ON : ~SYNC_ON,
                                  load_hsync ? SYNC_ON : ~SYNC_ON};
              if (!load_active)        out_data <= '0;
              else if (in_pixel_valid) out_data <= in_pixel_data;
              else                     out_data <= UNDERFLOW_COLOR;
              if (nx_h == H_LAST) begin
                nx_h <= '0;
                nx_v <= (nx_v == V_LAST) ? '0 : nx_v + 1'b1;
              end else begin
                nx_h <= nx_h + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
  always_ff @(posedge aclk) begin
    if (areset)
      out_underflow_count <= '0;
    else if (in_clear_status)
      out_underflow_count <= underflow_evt ? 16'd1 : 16'd0;
    else if (underflow_evt && (out_underflow_count != '1))
      out_underflow_count <= out_underflow_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ibis_tmds_timing.sv
// Bench for ibis_tmds_timing on a tiny 8x5 raster: vector table, directed sequences and
// randomized stimulus against a raster model driven by strobe/pixel counts.
module tb_ibis_tmds_timing;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        aclk = 1'b0;
  logic        areset, in_run, in_clear_status, in_pixel_valid;
  logic [23:0] in_pixel_data;
  logic        out_pixel_ready, out_tmds_enable, out_pixel_strobe, out_data_enable;
  logic [1:0]  out_control0;
  logic [23:0] out_data;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_frame_start, out_underflow;
`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
  logic [15:0] out_underflow_count;
`endif

  always #5 aclk = ~aclk;

  ibis_tmds_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0)
  ) dut (
    .aclk(aclk), .areset(areset), .in_run(in_run), .in_clear_status(in_clear_status),
    .in_pixel_valid(in_pixel_valid), .in_pixel_data(in_pixel_data),
    .out_pixel_ready(out_pixel_ready), .out_tmds_enable(out_tmds_enable),
    .out_pixel_strobe(out_pixel_strobe), .out_data_enable(out_data_enable),
    .out_control0(out_control0), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_frame_start(out_frame_start), .out_underflow(out_underflow)
`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
    , .out_underflow_count(out_underflow_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: streaming is described by cycles since start and pixels loaded
  bit          m_on, m_prev_run, m_just;
  int          m_cnt, m_k, m_last;
  int          m_x, m_y, m_count;
  bit          m_de, m_fs, m_uf;
  logic [1:0]  m_ctrl;
  logic [23:0] m_data;
  bit          e_strobe, e_ready, e_idle;
  int          e_h, e_v;

  function automatic bit px_active(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  task automatic model_blank();
    m_x = 0; m_y = 0; m_de = 0; m_fs = 0; m_ctrl = 2'b11; m_data = '0;
  endtask

  task automatic model_reset();
    m_on = 0; m_prev_run = 0; m_just = 0; m_cnt = 0; m_k = 0; m_last = 0;
    m_uf = 0; m_count = 0;
    model_blank();
  endtask

  task automatic model_comb();
    e_strobe = m_on && (m_cnt % 10 == 9);
    e_h      = m_k % HT;
    e_v      = (m_k / HT) % VT;
    e_idle   = e_strobe && !m_prev_run && !in_run && (m_k % FRAME == 0);
    e_ready  = e_strobe && px_active(e_h, e_v) && !e_idle;
  endtask

  task automatic model_edge();
    model_comb();
    if (areset) begin
      model_reset();
    end else begin
      m_just = 0;
      if (in_clear_status) begin m_uf = 0; m_count = 0; end
      if (!m_on) begin
        if (in_run) begin m_on = 1; m_cnt = 0; m_k = 0; end
      end else if (e_idle) begin
        m_on = 0; m_cnt = 0; m_k = 0;
        model_blank();
      end else begin
        if (e_strobe) begin
          m_x    = e_h;
          m_y    = e_v;
          m_fs   = (e_h == 0) && (e_v == 0);
          m_de   = px_active(e_h, e_v);
          m_ctrl = {(e_v >= VA + VF && e_v < VA + VF + VS) ? 1'b0 : 1'b1,
                    (e_h >= HA + HF && e_h < HA + HF + HS) ? 1'b0 : 1'b1};
          m_data = !m_de ? 24'h0 : (in_pixel_valid ? in_pixel_data : 24'hFF00FF);
          if (e_ready && !in_pixel_valid) begin
            m_uf = 1;
            if (m_count < 65535) m_count++;
          end
          m_last = m_k % FRAME;
          m_just = 1;
          m_k++;
        end
        m_cnt++;
      end
      m_prev_run = in_run;
    end
  endtask

  task automatic check_all();
    model_comb();
    chk("strobe",      32'(out_pixel_strobe), 32'(e_strobe));
    chk("ready",       32'(out_pixel_ready),  32'(e_ready));
    chk("tmds_enable", 32'(out_tmds_enable),  32'(m_on));
    chk("data_enable", 32'(out_data_enable),  32'(m_de));
    chk("control0",    32'(out_control0),     32'(m_ctrl));
    chk("data",        32'(out_data),         32'(m_data));
    chk("x",           32'(out_x),            32'(m_x));
    chk("y",           32'(out_y),            32'(m_y));
    chk("frame_start", 32'(out_frame_start),  32'(m_fs));
    chk("underflow",   32'(out_underflow),    32'(m_uf));
`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
    chk("uf_count",    32'(out_underflow_count), 32'(m_count));
`endif
  endtask

  task automatic step();
    check_all();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic advance_to(input int idx);
    int n;
    n = 0;
    while (!(m_just && m_last == idx) && n < 1000) begin
      step();
      n++;
    end
    chk($sformatf("advance_to_%0d", idx), 32'(n < 1000), 32'd1);
  endtask

  typedef struct {
    logic        valid;
    logic [23:0] pix;
    int          x;
    int          y;
    logic        de;
    logic [1:0]  ctrl;
    logic [23:0] data;
  } vec_t;

  vec_t tbl[16];
  int   n, n_ready, n_de, n_vs, n_hs, n_strobe;

  initial begin
    tbl[0]  = '{1'b1, 24'hA00000, 0, 0, 1'b1, 2'b11, 24'hA00000};
    tbl[1]  = '{1'b1, 24'hA00001, 1, 0, 1'b1, 2'b11, 24'hA00001};
    tbl[2]  = '{1'b1, 24'hA00002, 2, 0, 1'b1, 2'b11, 24'hA00002};
    tbl[3]  = '{1'b1, 24'hA00003, 3, 0, 1'b1, 2'b11, 24'hA00003};
    tbl[4]  = '{1'b0, 24'hBBBBBB, 4, 0, 1'b0, 2'b11, 24'h000000};
    tbl[5]  = '{1'b1, 24'hBBBBBB, 5, 0, 1'b0, 2'b10, 24'h000000};
    tbl[6]  = '{1'b1, 24'hBBBBBB, 6, 0, 1'b0, 2'b10, 24'h000000};
    tbl[7]  = '{1'b1, 24'hBBBBBB, 7, 0, 1'b0, 2'b11, 24'h000000};
    tbl[8]  = '{1'b1, 24'hA00010, 0, 1, 1'b1, 2'b11, 24'hA00010};
    tbl[9]  = '{1'b1, 24'hA00011, 1, 1, 1'b1, 2'b11, 24'hA00011};
    tbl[10] = '{1'b0, 24'h123456, 2, 1, 1'b1, 2'b11, 24'hFF00FF};
    tbl[11] = '{1'b1, 24'hA00013, 3, 1, 1'b1, 2'b11, 24'hA00013};
    tbl[12] = '{1'b1, 24'hBBBBBB, 4, 1, 1'b0, 2'b11, 24'h000000};
    tbl[13] = '{1'b1, 24'hBBBBBB, 5, 1, 1'b0, 2'b10, 24'h000000};
    tbl[14] = '{1'b1, 24'hBBBBBB, 6, 1, 1'b0, 2'b10, 24'h000000};
    tbl[15] = '{1'b1, 24'hBBBBBB, 7, 1, 1'b0, 2'b11, 24'h000000};

    areset = 1'b1; in_run = 1'b0; in_clear_status = 1'b0;
    in_pixel_valid = 1'b0; in_pixel_data = '0;
    model_reset();
    repeat (3) begin @(posedge aclk); model_edge(); #1; end

    chk("rst_tmds",     32'(out_tmds_enable),  32'd0);
    chk("rst_strobe",   32'(out_pixel_strobe), 32'd0);
    chk("rst_ready",    32'(out_pixel_ready),  32'd0);
    chk("rst_de",       32'(out_data_enable),  32'd0);
    chk("rst_ctrl",     32'(out_control0),     32'd3);
    chk("rst_data",     32'(out_data),         32'd0);
    chk("rst_xy",       32'({out_y, out_x}),   32'd0);
    chk("rst_fs",       32'(out_frame_start),  32'd0);
    chk("rst_uf",       32'(out_underflow),    32'd0);

    areset = 1'b0;
    step();
    step();
    in_run = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      in_pixel_valid = tbl[i].valid;
      in_pixel_data  = tbl[i].pix;
      if (i == 0) begin
        repeat (9) step();
        chk("first_strobe", 32'(out_pixel_strobe), 32'd1);
        step();
        chk("first_fs", 32'(out_frame_start), 32'd1);
      end else begin
        repeat (10) step();
      end
      chk($sformatf("tbl%0d_x", i),    32'(out_x),           32'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i),    32'(out_y),           32'(tbl[i].y));
      chk($sformatf("tbl%0d_de", i),   32'(out_data_enable), 32'(tbl[i].de));
      chk($sformatf("tbl%0d_ctrl", i), 32'(out_control0),    32'(tbl[i].ctrl));
      chk($sformatf("tbl%0d_data", i), 32'(out_data),        32'(tbl[i].data));
    end

    in_pixel_valid = 1'b1;
    in_pixel_data  = 24'h55AA55;
    repeat (30) step();
    chk("uf_sticky", 32'(out_underflow), 32'd1);
`ifdef IBIS_TMDS_TIMING_UNDERFLOW_COUNT_EN
    chk("uf_count_one", 32'(out_underflow_count), 32'd1);
`endif
    in_clear_status = 1'b1;
    step();
    in_clear_status = 1'b0;
    chk("uf_cleared", 32'(out_underflow), 32'd0);

    advance_to(FRAME - 1);
    n_ready = 0; n_de = 0; n_vs = 0; n_hs = 0; n_strobe = 0;
    for (int c = 0; c < 10 * FRAME; c++) begin
      step();
      if (out_pixel_ready)  n_ready++;
      if (out_pixel_strobe) n_strobe++;
      if (out_data_enable)  n_de++;
      if (!out_control0[1]) n_vs++;
      if (!out_control0[0]) n_hs++;
    end
    chk("frame_ready",  32'(n_ready),  32'd8);
    chk("frame_strobe", 32'(n_strobe), 32'd40);
    chk("frame_de",     32'(n_de),     32'd80);
    chk("frame_vsync",  32'(n_vs),     32'd80);
    chk("frame_hsync",  32'(n_hs),     32'd100);

    advance_to(1);
    in_run = 1'b0;
    n = 0;
    for (int c = 0; c < 600 && out_tmds_enable; c++) begin
      step();
      if (out_pixel_strobe) n++;
    end
    chk("stop_strobes", 32'(n), 32'd39);
    chk("stop_tmds",    32'(out_tmds_enable), 32'd0);
    chk("stop_ctrl",    32'(out_control0),    32'd3);
    chk("stop_de",      32'(out_data_enable), 32'd0);

    in_run = 1'b1;
    step();
    advance_to(1);
    in_run = 1'b0;
    repeat (50) step();
    in_run = 1'b1;
    advance_to(FRAME - 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_frame_start && n < 20);
    chk("resume_no_gap", 32'(n), 32'd10);
    chk("resume_tmds",   32'(out_tmds_enable), 32'd1);

    advance_to(3 * HT + 5);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("mrst_tmds", 32'(out_tmds_enable), 32'd0);
    chk("mrst_ctrl", 32'(out_control0),    32'd3);
    chk("mrst_xy",   32'({out_y, out_x}),  32'd0);
    chk("mrst_de",   32'(out_data_enable), 32'd0);
    step();
    n = 0;
    do begin
      step();
      n++;
    end while (!out_frame_start && n < 30);
    chk("mrst_restart", 32'(n), 32'd10);

    for (int c = 0; c < 3000; c++) begin
      in_pixel_valid  = ($urandom_range(0, 3) != 0);
      in_pixel_data   = 24'($urandom);
      in_clear_status = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) in_run = ~in_run;
      areset = ($urandom_range(0, 999) == 0);
      step();
    end
    areset = 1'b0;
    in_clear_status = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
